// File: rtl/serial_command_decoder_if.sv
// Byte-in / command-out bundle between the UART receiver, the command
// decoder and the rover control logic.
interface serial_command_decoder_if #(
  parameter int MAXLEN = 8
);
  logic [7:0]          rxByte;
  logic                rxValid;
  logic [7:0]          cmdId;
  logic [7:0]          cmdLen;
  logic [MAXLEN*8-1:0] cmdPayload;
  logic                cmdValid;
  logic                errChecksum;
  logic                errLength;
  logic                errTimeout;
  logic                busy;

  modport master (
    output rxByte, rxValid,
    input  cmdId, cmdLen, cmdPayload, cmdValid,
    input  errChecksum, errLength, errTimeout, busy
  );

  modport slave (
    input  rxByte, rxValid,
    output cmdId, cmdLen, cmdPayload, cmdValid,
    output errChecksum, errLength, errTimeout, busy
  );
endinterface

// File: rtl/serial_command_decoder.sv
// Parses SYNC/ID/LEN/payload/XOR-checksum frames from the CPU serial link and
// presents each validated command as a registered word with a one-cycle strobe.
module serial_command_decoder #(
  parameter int          CLKFREQ    = 100_000_000,
  parameter int          TIMEOUT_US = 1000,
  parameter int          MAXLEN     = 8,
  parameter logic [7:0]  SYNCBYTE   = 8'hA5
) (
  input  logic                        sclk,
  input  logic                        rstn,
  serial_command_decoder_if.slave     bus
);

  localparam int TIMEOUT_CYCLES = (CLKFREQ / 1_000_000) * TIMEOUT_US;
  localparam int CNTW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDXW           = $clog2(MAXLEN + 1);
  localparam logic [CNTW-1:0] CNT_TERM = CNTW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, GETID, GETLEN, GETDATA, GETCSUM, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              id_q, id_d;
  logic [7:0]              len_q, len_d;
  logic [MAXLEN-1:0][7:0]  pay_q, pay_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [7:0]              xor_q, xor_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;

  logic [7:0]              cmd_id_q, cmd_id_d;
  logic [7:0]              cmd_len_q, cmd_len_d;
  logic [MAXLEN-1:0][7:0]  cmd_pay_q, cmd_pay_d;
  logic                    cmd_vld_q, cmd_vld_d;
  logic                    err_cs_q, err_cs_d;
  logic                    err_len_q, err_len_d;
  logic                    err_to_q, err_to_d;

  logic in_frame;
  logic timeout_hit;

  assign in_frame = (state_q == GETID) || (state_q == GETLEN) ||
                    (state_q == GETDATA) || (state_q == GETCSUM);

  // Terminal count is judged on the value the counter would take this cycle,
  // so a byte on that same cycle still wins.
  assign timeout_hit = in_frame && !bus.rxValid &&
                       ((cnt_q + CNTW'(1)) == CNT_TERM);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    pay_d     = pay_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    cnt_d     = cnt_q;
    cmd_id_d  = cmd_id_q;
    cmd_len_d = cmd_len_q;
    cmd_pay_d = cmd_pay_q;
    cmd_vld_d = 1'b0;
    err_cs_d  = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;

    if (in_frame) cnt_d = bus.rxValid ? '0 : cnt_q + CNTW'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.rxValid && bus.rxByte == SYNCBYTE) begin
          xor_d   = '0;
          state_d = GETID;
        end
      end
      GETID: begin
        if (bus.rxValid) begin
          id_d    = bus.rxByte;
          xor_d   = xor_q ^ bus.rxByte;
          state_d = GETLEN;
        end
      end
      GETLEN: begin
        if (bus.rxValid) begin
          if (bus.rxByte > 8'(MAXLEN)) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end else begin
            // Zero-length frames also latch LEN and clear staging so the
            // committed word never carries a previous frame's payload.
            len_d   = bus.rxByte;
            pay_d   = '0;
            idx_d   = '0;
            xor_d   = xor_q ^ bus.rxByte;
            state_d = (bus.rxByte == 8'd0) ? GETCSUM : GETDATA;
          end
        end
      end
      GETDATA: begin
        if (bus.rxValid) begin
          for (int i = 0; i < MAXLEN; i++)
            if (idx_q == IDXW'(i)) pay_d[i] = bus.rxByte;
          xor_d = xor_q ^ bus.rxByte;
          idx_d = idx_q + IDXW'(1);
          if (8'(idx_q) == len_q - 8'd1) state_d = GETCSUM;
        end
      end
      GETCSUM: begin
        if (bus.rxValid) begin
          if (bus.rxByte == xor_q) begin
            state_d = DONE;
          end else begin
            err_cs_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DONE: begin
        cmd_id_d  = id_q;
        cmd_len_d = len_q;
        cmd_pay_d = pay_q;
        cmd_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      err_to_d = 1'b1;
      state_d  = IDLE;
    end

    if (state_d == IDLE) cnt_d = '0;
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      id_q      <= '0;
      len_q     <= '0;
      pay_q     <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      cnt_q     <= '0;
      cmd_id_q  <= '0;
      cmd_len_q <= '0;
      cmd_pay_q <= '0;
      cmd_vld_q <= 1'b0;
      err_cs_q  <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      pay_q     <= pay_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      cnt_q     <= cnt_d;
      cmd_id_q  <= cmd_id_d;
      cmd_len_q <= cmd_len_d;
      cmd_pay_q <= cmd_pay_d;
      cmd_vld_q <= cmd_vld_d;
      err_cs_q  <= err_cs_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
    end
  end

  assign bus.cmdId       = cmd_id_q;
  assign bus.cmdLen      = cmd_len_q;
  assign bus.cmdPayload  = cmd_pay_q;
  assign bus.cmdValid    = cmd_vld_q;
  assign bus.errChecksum = err_cs_q;
  assign bus.errLength   = err_len_q;
  assign bus.errTimeout  = err_to_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/serial_command_decoder.md
Name: serial_command_decoder

Overview:
Receive-side counterpart of the rover's CPU serial link. Takes bytes strobed out of the UART receiver and parses framed command messages from the CPU: SYNC, ID, LEN, payload, checksum. Delivers each validated command to the rover control logic as a registered, single-cycle-qualified word. Flags checksum, length and inter-byte timeout errors.

Parameters:
CLKFREQ, 100_000_000, sclk frequency in Hz
TIMEOUT_US, 1000, maximum gap between bytes inside a frame, in microseconds
MAXLEN, 8, maximum payload bytes per frame (1..32)
SYNCBYTE, 8'hA5, frame start marker

Ports:
sclk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
rxByte  input  8  byte from UART receiver
rxValid  input  1  one-cycle strobe; rxByte valid this cycle
cmdId  output  8  ID of last valid command
cmdLen  output  8  payload length of last valid command
cmdPayload  output  MAXLEN*8  payload; byte i at [8i+7:8i]; unused bytes zero
cmdValid  output  1  one-cycle pulse; cmd* outputs updated this cycle
errChecksum  output  1  one-cycle pulse on checksum mismatch
errLength  output  1  one-cycle pulse on LEN > MAXLEN
errTimeout  output  1  one-cycle pulse on inter-byte timeout
busy  output  1  high while not in IDLE

Behaviour:
- Reset: clock is sclk. Reset is asynchronous and active-low (rstn). All outputs are 0, state is IDLE, and the staging registers and counters are 0.
- No backpressure. The block accepts a byte on every rxValid cycle.
- Checksum is the XOR of the ID, LEN and all payload bytes. The frame is valid when the received checksum byte equals this XOR.
- States:
  - IDLE: rxValid with rxByte==SYNCBYTE -> GETID and clear the running XOR. Other bytes are discarded.
  - GETID: store the ID, XOR it in -> GETLEN.
  - GETLEN:
    - LEN > MAXLEN -> pulse errLength, go to IDLE.
    - LEN == 0 -> GETCSUM.
    - Otherwise store LEN, clear the staging payload and byte index -> GETDATA.
  - GETDATA: store the byte at the index, XOR it in, increment the index. When index reaches LEN-1 on a byte -> GETCSUM.
  - GETCSUM:
    - On a match -> DONE.
    - On a mismatch -> pulse errChecksum, go to IDLE.
  - DONE: copy staging into cmdId/cmdLen/cmdPayload, pulse cmdValid, go to IDLE. The DONE cycle ignores rxValid; the UART byte rate guarantees no byte arrives here.
- Latency: cmdValid rises 2 sclk cycles after the rxValid of the checksum byte. The checksum is registered in GETCSUM and committed in DONE.
- cmd* outputs hold their values until the next valid frame. Error frames never modify cmd*.
- The SYNCBYTE value inside a frame is treated as ordinary data. There is no mid-frame resync.
- Timeout:
  - The limit is TIMEOUT_CYCLES = (CLKFREQ/1_000_000)*TIMEOUT_US. The counter width holds this value.
  - The counter clears on every accepted byte and on entry to IDLE. It increments in GETID, GETLEN, GETDATA and GETCSUM.
  - When the count reaches TIMEOUT_CYCLES-1 with no rxValid: pulse errTimeout, go to IDLE, and discard the partial frame.
  - If a byte arrives on the same cycle as the terminal count, the byte wins and there is no timeout.
- At most one error pulse per frame. Error pulses and cmdValid are mutually exclusive.
- Reset asserted mid-frame aborts the frame immediately. No pulses are generated and cmd* clear to 0.

Test Plan:
- Valid frame A5 10 02 34 56 70 -> one cmdValid pulse 2 cycles after the 0x70 strobe; cmdId=0x10, cmdLen=2, cmdPayload[15:0]=16'h5634, upper bytes 0.
- Zero-length frame A5 20 00 20 -> cmdValid; cmdId=0x20, cmdLen=0, cmdPayload=0. Then frame A5 10 02 34 56 71 -> errChecksum pulse, no cmdValid, cmd* still hold 0x20/0/0.
- Garbage 00 FF 5A, then A5 10 02 34 56 70 -> the leading bytes are ignored (busy stays 0 until A5); the frame decodes as in scenario 1.
- Length violation A5 30 09 (MAXLEN=8) -> errLength pulse the cycle after LEN; busy drops. Following bytes 41 42 are ignored until the next A5.
- Timeout with TIMEOUT_US=10 and CLKFREQ=100 MHz: A5 10 then silence -> errTimeout exactly 1000 cycles after the 0x10 strobe. A second run with a byte strobed on cycle 999 -> no timeout.
- rstn low for 3 cycles after A5 10 02 34 -> all outputs 0. Then full frame A5 11 01 AB BB (11^01^AB=BB) -> cmdValid, cmdId=0x11, cmdPayload[7:0]=0xAB.
